frame_sync_rx: RTL

- Receive-side frame synchroniser and bit packer for the BPSK/ConvCode link.
- The transmit side emits frames as a SYNC_LEN-bit sync word followed by FRAME_LEN payload bits, driven by free-running bit counters.
- This block is the reading end of that framing. It hunts for the sync word in the hard-decision bit stream, counts payload bits, and packs them MSB-first into WORD_W-bit words.
- It holds lock across frames with a flywheel miss counter.

---
 rtl/frame_pkg.sv | 34 +++
 rtl/counter.sv | 43 ++++
 rtl/sync_correlator.sv | 63 ++++++
 rtl/frame_sync_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared framing definitions for the BPSK/ConvCode link.
// Holds the default frame geometry and sync pattern so the TX framer and the RX
// synchroniser agree, the receiver state encoding, and a popcount helper used by
// the sync correlator.
package frame_pkg;

  localparam int unsigned SYNC_LEN  = 16;
  localparam logic [31:0] SYNC_WORD = 32'h0000_EB90;
  localparam int unsigned FRAME_LEN = 64;
  localparam int unsigned WORD_W    = 8;
  localparam int unsigned ERR_TOL   = 1;
  localparam int unsigned MISS_MAX  = 3;

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;

  typedef enum logic [1:0] {
    StSearch  = SEARCH,
    StPayload = PAYLOAD,
    StCheck   = CHECK
  } state_e;

  // Number of set bits in a 32-bit vector; narrower operands are zero-extended.
  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/counter.sv
// Common modulo-N up counter.
// Counts 0..N-1 and wraps to 0 while en is high; clr forces 0 and takes
// priority over en.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   en     count enable
//   clr    synchronous clear
//   count  current count value
module counter #(
  parameter int unsigned N = 64,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == W'(N - 1)) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sync_correlator.sv
// Sync word correlator.
// Holds the SYNC_LEN-bit sync shift register and compares the value that
// includes the bit currently presented (i.e. the value after this shift)
// against SYNC_WORD, so a decision can be taken on the same cycle the last
// sync bit arrives.
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   shift_en     shift bit_in into the register this cycle
//   clr          synchronous clear of the register (priority over shift_en)
//   bit_in       received bit
//   exact_match  shifted value equals SYNC_WORD
//   within_tol   shifted value differs from SYNC_WORD in at most ERR_TOL bits
module sync_correlator #(
  parameter int unsigned         SYNC_LEN  = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 16'hEB90,
  parameter int unsigned         ERR_TOL   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic clr,
  input  logic bit_in,
  output logic exact_match,
  output logic within_tol
);

  import frame_pkg::*;

  logic [SYNC_LEN-1:0] sr_q;
  logic [SYNC_LEN-1:0] sr_d;
  logic [SYNC_LEN-1:0] sr_next;
  logic [SYNC_LEN-1:0] diff;
  int unsigned         errs;

  // Oldest bit falls off the top; the newest bit enters at the LSB.
  assign sr_next = SYNC_LEN'({sr_q, bit_in});

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (shift_en) begin
      sr_d = sr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  always_comb begin
    diff        = sr_next ^ SYNC_WORD;
    errs        = popcount32(32'(diff));
    exact_match = (diff == '0);
    within_tol  = (errs <= ERR_TOL);
  end

endmodule

// File: rtl/frame_sync_rx.sv
// Receive-side frame synchroniser and bit packer.
// Hunts for the sync word in the hard-decision bit stream, then packs each
// frame's payload MSB-first into WORD_W-bit words. After every frame the next
// sync slot is checked with error tolerance; MISS_MAX consecutive failed checks
// drop lock and restart the hunt.
// Ports:
//   clk_sig      system clock
//   reset_sig    asynchronous active-low reset
//   bit_in       received hard-decision bit
//   bit_valid    bit_in valid this cycle; nothing advances when low
//   data_out     packed payload word
//   data_valid   one-cycle strobe qualifying data_out
//   frame_start  with data_valid on the first word of a frame
//   frame_end    with data_valid on the last word of a frame
//   locked       frame lock indicator
module frame_sync_rx #(
  parameter int unsigned         SYNC_LEN  = frame_pkg::SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(frame_pkg::SYNC_WORD),
  parameter int unsigned         FRAME_LEN = frame_pkg::FRAME_LEN,
  parameter int unsigned         WORD_W    = frame_pkg::WORD_W,
  parameter int unsigned         ERR_TOL   = frame_pkg::ERR_TOL,
  parameter int unsigned         MISS_MAX  = frame_pkg::MISS_MAX
) (
  input  logic              clk_sig,
  input  logic              reset_sig,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              locked
);

  import frame_pkg::*;

  localparam int unsigned CNT_N  = (FRAME_LEN > SYNC_LEN) ? FRAME_LEN : SYNC_LEN;
  localparam int unsigned CNT_W  = $clog2(CNT_N);
  localparam int unsigned WORDS  = FRAME_LEN / WORD_W;
  localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

  state_e              state_q, state_d;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic                locked_q, locked_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   dout_q, dout_d;
  logic                dv_q, dv_d;
  logic                fs_q, fs_d;
  logic                fe_q, fe_d;

  logic [CNT_W-1:0]    bit_cnt;
  logic                cnt_en, cnt_clr;
  logic                sr_shift, sr_clr;
  logic                exact_match, within_tol;
  int unsigned         bit_pos, word_idx;

  counter #(
    .N (CNT_N),
    .W (CNT_W)
  ) u_bit_cnt (
    .clk   (clk_sig),
    .rst_n (reset_sig),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (bit_cnt)
  );

  sync_correlator #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD),
    .ERR_TOL   (ERR_TOL)
  ) u_corr (
    .clk         (clk_sig),
    .rst_n       (reset_sig),
    .shift_en    (sr_shift),
    .clr         (sr_clr),
    .bit_in      (bit_in),
    .exact_match (exact_match),
    .within_tol  (within_tol)
  );

  always_comb begin
    bit_pos  = 32'(bit_cnt) % WORD_W;
    word_idx = 32'(bit_cnt) / WORD_W;
    miss_inc = miss_q + MISS_W'(1);
  end

  // The count restarts at every state change so PAYLOAD and CHECK both see
  // their own bits numbered from 0.
  assign cnt_en  = bit_valid && (state_q != StSearch);
  assign cnt_clr = bit_valid && (state_d != state_q);

  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    word_d   = word_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    sr_shift = 1'b0;
    sr_clr   = 1'b0;

    if (bit_valid) begin
      case (state_q)
        StSearch: begin
          sr_shift = 1'b1;
          if (exact_match) begin
            state_d = StPayload;
            miss_d  = '0;
          end
        end

        StPayload: begin
          word_d = WORD_W'({word_q, bit_in});
          if (bit_pos == WORD_W - 1) begin
            dout_d = word_d;
            dv_d   = 1'b1;
            fs_d   = (word_idx == 0);
            fe_d   = (word_idx == WORDS - 1);
          end
          if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
            state_d = StCheck;
            sr_clr  = 1'b1;
          end
        end

        StCheck: begin
          sr_shift = 1'b1;
          if (bit_cnt == CNT_W'(SYNC_LEN - 1)) begin
            if (within_tol) begin
              locked_d = 1'b1;
              miss_d   = '0;
              state_d  = StPayload;
            end else begin
              miss_d = miss_inc;
              if (miss_inc == MISS_W'(MISS_MAX)) begin
                // Lock lost: hunt again from fresh bits only.
                locked_d = 1'b0;
                state_d  = StSearch;
                sr_shift = 1'b0;
                sr_clr   = 1'b1;
              end else begin
                // Flywheel: trust the frame timing and keep delivering.
                state_d = StPayload;
              end
            end
          end
        end

        default: begin
          state_d = StSearch;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      state_q  <= StSearch;
      miss_q   <= '0;
      locked_q <= 1'b0;
      word_q   <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      word_q   <= word_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign locked      = locked_q;

endmodule
